qpsk_frame_tx: RTL

QPSK_FRAME_TX -- requirements
Module: qpsk_frame_tx

---
 rtl/qpsk_frame_pkg.sv | 27 ++
 rtl/bit_timer.sv | 35 +++
 rtl/qpsk_frame_tx.sv | 118 +++++++++++
 3 files changed

// File: rtl/qpsk_frame_pkg.sv
// Shared constants, FSM state type and checksum helper for the QPSK frame
// transmitter. The optional checksum byte is controlled by QPSK_FRAME_CHKSUM_EN.
package qpsk_frame_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'b1100_1100;
    localparam int         HEAD_BITS      = 8;
    localparam int         DATA_BITS      = 40;
    localparam int         CHK_BITS       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } qpsk_state_e;

    // Modulo-256 sum of the payload bytes.
    function automatic logic [7:0] payload_checksum(input logic [DATA_BITS-1:0] payload);
        logic [7:0] sum;
        sum = 8'd0;
        for (int i = 0; i < DATA_BITS / 8; i++) begin
            sum = sum + payload[8*i +: 8];
        end
        return sum;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts SAMPLE cycles per serial bit while the frame runs,
// flags the first cycle of each bit and strobes the last one.
module bit_timer #(
    parameter int SAMPLE = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic bit_flag,
    output logic bit_end
);

    localparam logic [7:0] LAST_SAMPLE = 8'(SAMPLE - 1);

    logic [7:0] sample_cnt_q;

    // Sample counter: restarts on every frame start, wraps once per bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= 8'd0;
        end else if (start) begin
            sample_cnt_q <= 8'd0;
        end else if (run) begin
            sample_cnt_q <= (sample_cnt_q == LAST_SAMPLE) ? 8'd0 : sample_cnt_q + 8'd1;
        end
    end

    // Bit boundary strobes, only meaningful while a frame is running.
    always_comb begin
        bit_flag = run && (sample_cnt_q == 8'd0);
        bit_end  = run && (sample_cnt_q == LAST_SAMPLE);
    end

endmodule

// File: rtl/qpsk_frame_tx.sv
// QPSK frame transmitter: serialises HEADER + 40-bit payload (+ checksum when
// QPSK_FRAME_CHKSUM_EN is defined) MSB first, each bit held SAMPLE cycles.
// Handshake: a payload is taken on any rising edge where in_valid and in_ready
// are both 1; in_ready depends only on internal state, never on in_valid.
module qpsk_frame_tx
    import qpsk_frame_pkg::*;
#(
    parameter logic [7:0] HEADER = HEADER_DEFAULT,
    parameter int         SAMPLE = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] para_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 ser_o,
    output logic                 bit_flag,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic [1:0]           state_dbg
);

`ifdef QPSK_FRAME_CHKSUM_EN
    localparam int FRAME_BITS = HEAD_BITS + DATA_BITS + CHK_BITS;
`else
    localparam int FRAME_BITS = HEAD_BITS + DATA_BITS;
`endif
    localparam logic [5:0] LAST_HEAD = 6'(HEAD_BITS - 1);
    localparam logic [5:0] LAST_DATA = 6'(HEAD_BITS + DATA_BITS - 1);
    localparam logic [5:0] LAST_BIT  = 6'(FRAME_BITS - 1);

    qpsk_state_e           state_q, state_d;
    logic [5:0]            bit_cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] load_word;
    logic                  bit_end;
    logic                  last_bit_end;
    logic                  transfer;

    assign transfer     = in_valid && in_ready;
    assign last_bit_end = bit_end && (bit_cnt_q == LAST_BIT);
    assign state_dbg    = state_q;

`ifdef QPSK_FRAME_CHKSUM_EN
    assign load_word = {HEADER, para_in, payload_checksum(para_in)};
`else
    assign load_word = {HEADER, para_in};
`endif

    bit_timer #(
        .SAMPLE (SAMPLE)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (transfer),
        .run      (frame_busy),
        .bit_flag (bit_flag),
        .bit_end  (bit_end)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: advance at the bit boundaries that close each field.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (transfer) state_d = ST_HEAD;
            ST_HEAD: if (bit_end && bit_cnt_q == LAST_HEAD) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end && bit_cnt_q == LAST_DATA) begin
`ifdef QPSK_FRAME_CHKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = transfer ? ST_HEAD : ST_IDLE;
`endif
                end
            end
            ST_CHK: begin
`ifdef QPSK_FRAME_CHKSUM_EN
                if (last_bit_end) state_d = transfer ? ST_HEAD : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready in IDLE or in the final cycle of the final bit.
    always_comb begin
        frame_busy = (state_q != ST_IDLE);
        in_ready   = (state_q == ST_IDLE) || last_bit_end;
        frame_done = last_bit_end;
        ser_o      = frame_busy && shift_q[FRAME_BITS-1];
    end

    // Frame shift register and bit counter: load on transfer, shift per bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= 6'd0;
            shift_q   <= '0;
        end else if (transfer) begin
            bit_cnt_q <= 6'd0;
            shift_q   <= load_word;
        end else if (bit_end) begin
            bit_cnt_q <= bit_cnt_q + 6'd1;
            shift_q   <= {shift_q[FRAME_BITS-2:0], 1'b0};
        end
    end

endmodule
